// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
// Imported by the interface, lane logic and the lsu top.
package lsu_pkg;

    localparam int CPU_WIDTH       = 32;
    localparam int DMEM_BE_WIDTH   = 4;
    localparam int LSU_STATE_WIDTH = 2;

    typedef enum logic [LSU_STATE_WIDTH-1:0] {
        LSU_IDLE = 2'd0,
        LSU_WAIT = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response bundle and data-memory bus bundle.
// master drives the request, slave answers it.
interface lsu_req_if
    import lsu_pkg::*;
#(
    parameter int XLEN = CPU_WIDTH
);
    logic            req_valid;
    logic            req_ready;
    logic            req_load;
    logic            req_store;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_fault;

    modport master (
        output req_valid, req_load, req_store,
        output req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_load, req_store,
        input  req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

interface lsu_dmem_if
    import lsu_pkg::*;
#(
    parameter int XLEN = CPU_WIDTH
);
    logic                     dmem_req;
    logic                     dmem_we;
    logic [XLEN-1:0]          dmem_addr;
    logic [DMEM_BE_WIDTH-1:0] dmem_be;
    logic [XLEN-1:0]          dmem_wdata;
    logic                     dmem_ack;
    logic [XLEN-1:0]          dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/lsu_lane.sv
// Byte-lane steering, byte enables, load extension and legality check.
// Purely combinational; the lsu top registers everything it produces.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic                     load_i,
    input  logic                     store_i,
    input  logic [2:0]               funct3_i,
    input  logic [1:0]               addr_lo_i,
    input  logic [CPU_WIDTH-1:0]     wdata_i,
    input  logic [CPU_WIDTH-1:0]     rdata_i,
    output logic                     legal_o,
    output logic [DMEM_BE_WIDTH-1:0] be_o,
    output logic [CPU_WIDTH-1:0]     wdata_o,
    output logic [CPU_WIDTH-1:0]     rdata_o
);

    logic [CPU_WIDTH-1:0] shifted;
    logic                 is_byte;
    logic                 is_half;
    logic                 f3_ok;
    logic                 misal;

    assign is_byte = (funct3_i[1:0] == 2'b00);
    assign is_half = (funct3_i[1:0] == 2'b01);

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        unique case (1'b1)
            is_byte: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            is_half: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        rdata_o = shifted;
        case (funct3_i)
            F3_LB:   rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  rdata_o = {24'd0, shifted[7:0]};
            F3_LHU:  rdata_o = {16'd0, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

    always_comb begin
        if (load_i) begin
            f3_ok = funct3_i inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        end else begin
            f3_ok = funct3_i inside {F3_SB, F3_SH, F3_SW};
        end
        misal = (is_half && addr_lo_i[0]) ||
                ((funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));
        legal_o = (load_i ^ store_i) && f3_ok && !misal;
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction per accepted request.
// FSM and all registered outputs; lane logic lives in lsu_lane.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = CPU_WIDTH
)(
    input  logic       clk,
    input  logic       rst_n,
    lsu_req_if.slave   req,
    lsu_dmem_if.master dmem
);

    lsu_state_e                state_q;
    logic                      load_q;
    logic [2:0]                funct3_q;
    logic [1:0]                addr_lo_q;
    logic                      resp_valid_q;
    logic                      resp_fault_q;
    logic [XLEN-1:0]           resp_rdata_q;
    logic                      dmem_req_q;
    logic                      dmem_we_q;
    logic [XLEN-1:0]           dmem_addr_q;
    logic [DMEM_BE_WIDTH-1:0]  dmem_be_q;
    logic [XLEN-1:0]           dmem_wdata_q;

    logic                      idle;
    logic                      legal_d;
    logic [DMEM_BE_WIDTH-1:0]  be_d;
    logic [XLEN-1:0]           wdata_d;
    logic [XLEN-1:0]           rdata_d;

    assign idle = (state_q == LSU_IDLE);

    // In IDLE the lane decodes the incoming request; afterwards it
    // formats the returning word from the latched size and offset.
    lsu_lane u_lane (
        .load_i    (idle ? req.req_load : load_q),
        .store_i   (idle ? req.req_store : ~load_q),
        .funct3_i  (idle ? req.req_funct3 : funct3_q),
        .addr_lo_i (idle ? req.req_addr[1:0] : addr_lo_q),
        .wdata_i   (req.req_wdata),
        .rdata_i   (dmem.dmem_rdata),
        .legal_o   (legal_d),
        .be_o      (be_d),
        .wdata_o   (wdata_d),
        .rdata_o   (rdata_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= LSU_IDLE;
            load_q       <= 1'b0;
            funct3_q     <= 3'd0;
            addr_lo_q    <= 2'd0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= '0;
            dmem_wdata_q <= '0;
        end else begin
            unique case (state_q)
                LSU_IDLE: begin
                    if (req.req_valid) begin
                        load_q    <= req.req_load;
                        funct3_q  <= req.req_funct3;
                        addr_lo_q <= req.req_addr[1:0];
                        if (legal_d) begin
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= req.req_store;
                            dmem_addr_q  <= {req.req_addr[XLEN-1:2], 2'b00};
                            dmem_be_q    <= be_d;
                            dmem_wdata_q <= wdata_d;
                            state_q      <= LSU_WAIT;
                        end else begin
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                            resp_rdata_q <= '0;
                            state_q      <= LSU_RESP;
                        end
                    end
                end
                LSU_WAIT: begin
                    if (dmem.dmem_ack) begin
                        dmem_req_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b0;
                        resp_rdata_q <= load_q ? rdata_d : '0;
                        state_q      <= LSU_RESP;
                    end
                end
                LSU_RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_fault_q <= 1'b0;
                    resp_rdata_q <= '0;
                    state_q      <= LSU_IDLE;
                end
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

    assign req.req_ready    = idle;
    assign req.resp_valid   = resp_valid_q;
    assign req.resp_fault   = resp_fault_q;
    assign req.resp_rdata   = resp_rdata_q;
    assign dmem.dmem_req    = dmem_req_q;
    assign dmem.dmem_we     = dmem_we_q;
    assign dmem.dmem_addr   = dmem_addr_q;
    assign dmem.dmem_be     = dmem_be_q;
    assign dmem.dmem_wdata  = dmem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: vector table, scoreboard queue,
// plus hand-written reset-abort and back-to-back sequences.
module tb_lsu;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    lsu_req_if  rq ();
    lsu_dmem_if dm ();

    lsu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rq),
        .dmem  (dm)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrd;
        int          lat;
        logic        flt;
        logic [3:0]  be;
        logic [31:0] ewd;
        logic [31:0] erd;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    vec_t vecs[18];
    int   errs = 0;
    int   checks = 0;
    int   resp_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rq.resp_valid === 1'b1) begin
            resp_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected none");
            end else begin
                got = sb.pop_front();
                chk("resp_rdata", rq.resp_rdata, got.rdata);
                chk("resp_fault", {31'd0, rq.resp_fault}, {31'd0, got.fault});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (rq.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, rq.req_ready}, 32'd1);
    endtask

    task automatic do_req(input vec_t v);
        wait_ready();
        rq.req_load   = v.ld;
        rq.req_store  = v.st;
        rq.req_funct3 = v.f3;
        rq.req_addr   = v.addr;
        rq.req_wdata  = v.wdata;
        rq.req_valid  = 1'b1;
        sb.push_back('{v.flt ? 32'd0 : v.erd, v.flt});
        @(negedge clk);
        rq.req_valid = 1'b0;
        rq.req_addr  = $urandom;
        rq.req_wdata = $urandom;
        if (v.flt) begin
            chk("flt_dreq", {31'd0, dm.dmem_req}, 32'd0);
            chk("flt_valid", {31'd0, rq.resp_valid}, 32'd1);
            chk("flt_flag", {31'd0, rq.resp_fault}, 32'd1);
            @(negedge clk);
            chk("flt_ready", {31'd0, rq.req_ready}, 32'd1);
            chk("flt_dreq2", {31'd0, dm.dmem_req}, 32'd0);
        end else begin
            chk("dreq", {31'd0, dm.dmem_req}, 32'd1);
            chk("daddr", dm.dmem_addr, v.addr & 32'hFFFF_FFFC);
            chk("dbe", {28'd0, dm.dmem_be}, {28'd0, v.be});
            chk("dwe", {31'd0, dm.dmem_we}, {31'd0, v.st});
            chk("dwdata", dm.dmem_wdata, v.ewd);
            chk("busy", {31'd0, rq.req_ready}, 32'd0);
            for (int i = 0; i < v.lat; i++) begin
                @(negedge clk);
                chk("hold_req", {31'd0, dm.dmem_req}, 32'd1);
                chk("early_resp", {31'd0, rq.resp_valid}, 32'd0);
            end
            dm.dmem_ack   = 1'b1;
            dm.dmem_rdata = v.mrd;
            @(negedge clk);
            dm.dmem_ack   = 1'b0;
            dm.dmem_rdata = $urandom;
            chk("resp_pulse", {31'd0, rq.resp_valid}, 32'd1);
            chk("dreq_fall", {31'd0, dm.dmem_req}, 32'd0);
            chk("busy_resp", {31'd0, rq.req_ready}, 32'd0);
            @(negedge clk);
            chk("ready_back", {31'd0, rq.req_ready}, 32'd1);
            chk("pulse_end", {31'd0, rq.resp_valid}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pushes;
        int base;

        vecs[0]  = '{0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 2, 0, 4'hF, 32'hDEADBEEF, 0};
        vecs[1]  = '{1, 0, 3'b000, 32'h203, 0, 32'h80FF0000, 1, 0, 4'h8, 0, 32'hFFFFFF80};
        vecs[2]  = '{1, 0, 3'b100, 32'h203, 0, 32'h80FF0000, 0, 0, 4'h8, 0, 32'h00000080};
        vecs[3]  = '{0, 1, 3'b001, 32'h002, 32'h1234ABCD, 0, 1, 0, 4'hC, 32'hABCDABCD, 0};
        vecs[4]  = '{1, 0, 3'b001, 32'h002, 0, 32'h7FFE0000, 2, 0, 4'hC, 0, 32'h00007FFE};
        vecs[5]  = '{1, 0, 3'b010, 32'h101, 0, 0, 0, 1, 4'h0, 0, 0};
        vecs[6]  = '{1, 0, 3'b101, 32'h001, 0, 0, 0, 1, 4'h0, 0, 0};
        vecs[7]  = '{1, 0, 3'b010, 32'h010, 0, 32'hCAFEF00D, 1, 0, 4'hF, 0, 32'hCAFEF00D};
        vecs[8]  = '{1, 0, 3'b001, 32'h000, 0, 32'h00008001, 0, 0, 4'h3, 0, 32'hFFFF8001};
        vecs[9]  = '{1, 0, 3'b101, 32'h002, 0, 32'h80010000, 2, 0, 4'hC, 0, 32'h00008001};
        vecs[10] = '{0, 1, 3'b000, 32'h007, 32'h000000A5, 0, 1, 0, 4'h8, 32'hA5A5A5A5, 0};
        vecs[11] = '{1, 0, 3'b011, 32'h000, 0, 0, 0, 1, 4'h0, 0, 0};
        vecs[12] = '{0, 1, 3'b100, 32'h000, 0, 0, 0, 1, 4'h0, 0, 0};
        vecs[13] = '{1, 1, 3'b000, 32'h000, 0, 0, 0, 1, 4'h0, 0, 0};
        vecs[14] = '{0, 0, 3'b010, 32'h000, 0, 0, 0, 1, 4'h0, 0, 0};
        vecs[15] = '{0, 1, 3'b010, 32'h022, 0, 0, 0, 1, 4'h0, 0, 0};
        vecs[16] = '{1, 0, 3'b100, 32'h001, 0, 32'h0000FF00, 0, 0, 4'h2, 0, 32'h000000FF};
        vecs[17] = '{0, 1, 3'b001, 32'h000, 32'hFFFF1234, 0, 0, 0, 4'h3, 32'h12341234, 0};

        rst_n         = 1'b0;
        rq.req_valid  = 1'b0;
        rq.req_load   = 1'b0;
        rq.req_store  = 1'b0;
        rq.req_funct3 = 3'd0;
        rq.req_addr   = '0;
        rq.req_wdata  = '0;
        dm.dmem_ack   = 1'b0;
        dm.dmem_rdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, rq.req_ready}, 32'd1);
        chk("rst_valid", {31'd0, rq.resp_valid}, 32'd0);
        chk("rst_fault", {31'd0, rq.resp_fault}, 32'd0);
        chk("rst_rdata", rq.resp_rdata, 32'd0);
        chk("rst_dreq", {31'd0, dm.dmem_req}, 32'd0);
        chk("rst_we", {31'd0, dm.dmem_we}, 32'd0);
        chk("rst_be", {28'd0, dm.dmem_be}, 32'd0);
        chk("rst_addr", dm.dmem_addr, 32'd0);
        chk("rst_wdata", dm.dmem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) do_req(vecs[i]);

        // Reset while waiting for memory, then a late ack.
        wait_ready();
        rq.req_load   = 1'b1;
        rq.req_store  = 1'b0;
        rq.req_funct3 = 3'b010;
        rq.req_addr   = 32'h30;
        rq.req_valid  = 1'b1;
        @(negedge clk);
        rq.req_valid = 1'b0;
        chk("abort_dreq_on", {31'd0, dm.dmem_req}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_dreq_off", {31'd0, dm.dmem_req}, 32'd0);
        chk("abort_novalid", {31'd0, rq.resp_valid}, 32'd0);
        chk("abort_ready", {31'd0, rq.req_ready}, 32'd1);
        dm.dmem_ack   = 1'b1;
        dm.dmem_rdata = 32'h55AA55AA;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dm.dmem_ack = 1'b0;
        chk("late_ack_novalid", {31'd0, rq.resp_valid}, 32'd0);
        chk("late_ack_nodreq", {31'd0, dm.dmem_req}, 32'd0);
        do_req(vecs[7]);

        // Back-to-back with req_valid held and ack stuck high.
        wait_ready();
        base          = resp_cnt;
        pushes        = 0;
        rq.req_load   = 1'b1;
        rq.req_store  = 1'b0;
        rq.req_funct3 = 3'b010;
        rq.req_addr   = 32'h40;
        dm.dmem_rdata = 32'h11223344;
        dm.dmem_ack   = 1'b1;
        rq.req_valid  = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (rq.req_ready === 1'b1) begin
                sb.push_back('{32'h11223344, 1'b0});
                pushes++;
            end
            @(negedge clk);
        end
        rq.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        dm.dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("b2b_accepts", pushes, 32'd7);
        chk("b2b_resps", resp_cnt - base, 32'd7);
        chk("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the single-issue core, directly downstream of the ALU: takes the ALU's effective address (`alu_out`) plus `rs2_data` and the instruction's funct3. Runs one data-memory transaction over a req/ack handshake, with byte-lane steering and load sign/zero extension. Returns one result or fault pulse per accepted request; the core stalls while `req_ready` is low.

## Interface
- `XLEN`, default `CPU_WIDTH` (32): data/address width; only 32 is supported.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `req_valid` input 1: memory instruction presented.
- `req_ready` output 1: LSU idle; a request is accepted when `req_valid & req_ready`.
- `req_load` input 1: load request.
- `req_store` input 1: store request.
- `req_funct3` input 3: RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr` input XLEN: effective byte address (ALU output).
- `req_wdata` input XLEN: store data (rs2).
- `resp_valid` output 1: one-cycle result pulse; there is no backpressure.
- `resp_rdata` output XLEN: extended load data; 0 for stores and faults.
- `resp_fault` output 1: misaligned or illegal request, qualified by `resp_valid`.
- `dmem_req` output 1: memory request, held high until ack.
- `dmem_we` output 1: write enable.
- `dmem_addr` output XLEN: word address, `{req_addr[31:2],2'b00}`.
- `dmem_be` output 4: byte enables.
- `dmem_wdata` output XLEN: lane-replicated store data.
- `dmem_ack` input 1: memory completes the transaction this cycle.
- `dmem_rdata` input XLEN: read word, valid when `dmem_ack`.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - On accept, latch `addr[1:0]`, funct3, `req_load`/`req_store` and formatted store data.
  - Legal request: go to WAIT.
  - Illegal request: go to RESP with fault.
- **Illegal requests:**
  - both `req_load` and `req_store` high;
  - neither high;
  - load funct3 in {011,110,111};
  - store funct3 not in {000,001,010};
  - halfword with `addr[0]`=1;
  - word with `addr[1:0]`≠0.
- **WAIT:** `dmem_req`=1 with address/we/be/wdata stable. On `dmem_ack`, capture the extended `dmem_rdata` and go to RESP.
- **RESP:** `resp_valid`=1 for exactly one cycle, then go to IDLE. `req_ready`=0 in WAIT and RESP.
- **Store lanes:**
  - SB: `dmem_wdata`={4{wdata[7:0]}}, `be`=4'b0001<<addr[1:0].
  - SH: `dmem_wdata`={2{wdata[15:0]}}, `be`=4'b0011<<addr[1:0].
  - SW: wdata passed through, `be`=4'b1111.
- **Loads:** `dmem_we`=0, `be` as for the store of the same size. The word is shifted right by `addr[1:0]*8`.
  - LB/LH: sign-extend bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: full word.
- `dmem_ack` outside WAIT is ignored.
- `req_*` inputs are ignored outside IDLE.

## Timing
- Reset values:
  - state=IDLE, `req_ready`=1;
  - `resp_valid`=0, `resp_fault`=0, `resp_rdata`=0;
  - `dmem_req`=0, `dmem_we`=0, `dmem_be`=0;
  - `dmem_addr`=0, `dmem_wdata`=0.
- All outputs are registered except `req_ready`, which decodes state.
- Legal request accepted at edge N:
  - `dmem_req` high from cycle N+1.
  - Ack sampled at edge M (M≥N+1) gives `resp_valid` in cycle M+1.
  - `req_ready` is high again in cycle M+2.
  - Minimum occupancy is 3 cycles.
- Fault accepted at edge N: `resp_valid`/`resp_fault` high in cycle N+1, no `dmem_req` ever; `req_ready` is high in cycle N+2.
- `dmem_req` falls in the cycle after ack; the memory must not ack twice.
- `rst_n` low mid-WAIT:
  - Next edge returns to IDLE and clears `dmem_req` and all response outputs.
  - No `resp_valid` is produced for the aborted request.
  - A late ack is ignored.
- `rst_n` low during RESP: the pulse is suppressed from the next edge.

## Structure
- `defines.v` gains:
  - `` `LSU_STATE_WIDTH `` (2) and `` `LSU_IDLE/WAIT/RESP ``;
  - funct3 constants `` `F3_LB/LH/LW/LBU/LHU/SB/SH/SW ``;
  - `` `DMEM_BE_WIDTH `` (4).
- Sub-module `lsu_lane`: combinational store-lane replication, byte-enable generation, load extraction/extension and the legality check. `lsu` holds the FSM and registers.

## Test plan
- SW addr=0x100, wdata=0xDEADBEEF, ack 2 cycles after `dmem_req` -> `dmem_addr`=0x100, `be`=1111, `we`=1; `resp_valid` 1 cycle after ack, `resp_rdata`=0, fault=0.
- LB addr=0x203, `dmem_rdata`=0x80FF_0000 -> `be`=1000, `resp_rdata`=0xFFFFFF80; repeat as LBU -> 0x00000080.
- SH addr=0x002, wdata=0x1234ABCD -> `dmem_wdata`=0xABCDABCD, `be`=1100; LH addr=0x002 with rdata=0x7FFE0000 -> 0x00007FFE.
- LW addr=0x101 -> `resp_valid`+`resp_fault` next cycle, `dmem_req` never asserted, `req_ready` back the cycle after.
- `rst_n` low in WAIT, then `dmem_ack` asserted -> `dmem_req`=0 after the reset edge, no `resp_valid`, next legal request is serviced normally.
- Back-to-back requests with `req_valid` held high and spurious `dmem_ack` in IDLE -> exactly one `resp_valid` per accepted request, spurious acks ignored.
